// File: rtl/seq_detector_prog_pkg.sv
// Shared definitions for the programmable serial sequence detector.
//   state_t      : detector FSM states (IDLE = unconfigured, RUN = detecting)
//   DEF_MAX_LEN  : default maximum pattern length in bits
//   DEF_CNT_W    : default match-counter width
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear; when coincident with inc the count becomes 1
//   inc   : increment request, ignored once the count is all ones
//   count : current count value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            // The event that arrives together with a clear is still counted.
            count <= WIDTH'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector with Mealy match output.
//   clk, rst     : clock and synchronous active-high reset
//   cfg_load     : strobe capturing cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  : pattern, bit cfg_len-1 arrives first, bit 0 last
//   cfg_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      : synchronous clear of match_cnt
//   i_valid, i   : serial bit qualifier and data
//   o            : combinational match flag for the current bit
//   match_cnt    : saturating match count since last clear/configuration
//   armed        : a legal configuration is loaded
//   cfg_err      : one-cycle pulse after an illegal cfg_len was rejected
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    input  logic               i_valid,
    input  logic               i,
    output logic               o,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed,
    output logic               cfg_err
);

    localparam logic [MAX_LEN-1:0] ALL_ONES = '1;
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

    state_t               state, state_next;
    logic [MAX_LEN-1:0]   pat;
    logic [LEN_W-1:0]     len;
    logic                 ovl;
    logic [MAX_LEN-2:0]   hist;
    logic [LEN_W-1:0]     fill;

    logic                 cfg_ok;
    logic                 load_ok;
    logic                 window_hit;
    logic [MAX_LEN-1:0]   window;
    logic [MAX_LEN-1:0]   mask;

    assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign load_ok = cfg_load && cfg_ok;

    // Newest bit sits at position 0, matching the pattern's last serial bit.
    assign window = {hist, i};
    // Low len bits set; with len = 0 (IDLE) the mask is empty.
    assign mask   = ALL_ONES >> (LEN_MAX - len);

    assign window_hit = (((window ^ pat) & mask) == '0) &&
                        (fill >= (len - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o          = 1'b0;
        armed      = 1'b0;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                armed = 1'b1;
                o     = i_valid && !cfg_load && window_hit;
                if (load_ok) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat     <= '0;
            len     <= '0;
            ovl     <= 1'b0;
            hist    <= '0;
            fill    <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (load_ok) begin
                pat  <= cfg_pattern;
                len  <= cfg_len;
                ovl  <= cfg_overlap;
                hist <= '0;
                fill <= '0;
            end else if ((state == RUN) && i_valid && !cfg_load) begin
                hist <= window[MAX_LEN-2:0];
                // Non-overlapping mode restarts the fill so the next match
                // must be built entirely from bits after this one.
                if (o && !ovl) begin
                    fill <= '0;
                end else if (fill != LEN_MAX) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr || load_ok),
        .inc  (o),
        .count(match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised and directed bench for seq_detector_prog with a queue-based
// reference model and a scoreboard monitor.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               i_valid = 1'b0;
    logic               i = 1'b0;
    logic               o;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;
    logic               cfg_err;

    seq_detector_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .i_valid    (i_valid),
        .i          (i),
        .o          (o),
        .match_cnt  (match_cnt),
        .armed      (armed),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        bit o;
        int cnt;
        bit armed;
        bit err;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 1'b0;

    // Reference model: the bits seen since the last fill restart, kept as a list.
    bit               m_armed = 1'b0;
    bit [MAX_LEN-1:0] m_pat = '0;
    int               m_len = 0;
    bit               m_ovl = 1'b0;
    bit               hq[$];
    int               m_cnt = 0;
    bit               m_err = 1'b0;

    task automatic step(input bit r, input bit ld, input logic [MAX_LEN-1:0] p,
                        input int l, input bit ov, input bit cc, input bit v, input bit b);
        exp_t e;
        bit   legal;
        bit   mt;
        bit   sb;
        @(posedge clk);
        #1;
        rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(l);
        cfg_overlap = ov; cnt_clr = cc; i_valid = v; i = b;

        legal = ld && (l >= 1) && (l <= MAX_LEN);
        mt = 1'b0;
        if (m_armed && v && !ld && (hq.size() >= m_len - 1)) begin
            mt = 1'b1;
            for (int k = 0; k < m_len; k++) begin
                sb = (k == 0) ? b : hq[hq.size() - k];
                if (sb != m_pat[k]) mt = 1'b0;
            end
        end
        e.chk = started; e.o = mt; e.cnt = m_cnt; e.armed = m_armed; e.err = m_err;
        sbq.push_back(e);

        if (r) begin
            m_armed = 0; m_pat = '0; m_len = 0; m_ovl = 0; hq.delete(); m_cnt = 0; m_err = 0;
        end else begin
            m_err = ld && !legal;
            if (legal) begin
                m_armed = 1; m_pat = p; m_len = l; m_ovl = ov; hq.delete(); m_cnt = 0;
            end else begin
                if (m_armed && v && !ld) begin
                    hq.push_back(b);
                    if (hq.size() > MAX_LEN) void'(hq.pop_front());
                    if (mt && !m_ovl) hq.delete();
                end
                if (cc) m_cnt = mt ? 1 : 0;
                else if (mt && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input int l, input bit ov);
        step(0, 1, p, l, ov, 0, 0, 0);
    endtask

    // Serial bits, first bit in position n-1.
    task automatic feed(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(0, 0, '0, 0, 0, 0, 1, bits[k]);
    endtask

    // Monitor: every cycle the DUT presents o, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk) begin
                vectors++;
                if (o !== e.o) begin
                    miscompares++;
                    $display("FAIL o: got %b want %b at %0t", o, e.o, $time);
                end
                if (match_cnt !== CNT_W'(e.cnt)) begin
                    miscompares++;
                    $display("FAIL match_cnt: got %0d want %0d at %0t", match_cnt, e.cnt, $time);
                end
                if (armed !== e.armed) begin
                    miscompares++;
                    $display("FAIL armed: got %b want %b at %0t", armed, e.armed, $time);
                end
                if (cfg_err !== e.err) begin
                    miscompares++;
                    $display("FAIL cfg_err: got %b want %b at %0t", cfg_err, e.err, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int l;
        int sel;
        bit ld;
        bit cc;

        do_reset();
        started = 1'b1;

        // Overlapping 1101 on 1101101: hits on bits 4 and 7.
        load(8'b1101, 4, 1);
        feed(16'b1101101, 7);
        idle();

        // Non-overlapping: only bit 4 hits.
        load(8'b1101, 4, 0);
        feed(16'b1101101, 7);
        idle();

        // Illegal lengths while unconfigured.
        do_reset();
        load(8'b1101, 0, 1);
        load(8'b1101, 9, 1);
        feed(16'b1111, 4);
        idle();

        // Counter saturation and clear-with-match.
        load(8'b1, 1, 1);
        feed(16'b11111, 5);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        idle();

        // Gap in i_valid holds the partial match.
        load(8'b110, 3, 1);
        feed(16'b11, 2);
        idle(); idle(); idle();
        feed(16'b0, 1);
        idle();

        // Reset mid-sequence discards the partial match.
        load(8'b1101, 4, 1);
        feed(16'b110, 3);
        do_reset();
        load(8'b1101, 4, 1);
        feed(16'b1, 1);
        feed(16'b101, 3);
        idle();

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            ld  = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0) l = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 15);
            else if (sel < 7) l = $urandom_range(1, 3);
            else l = $urandom_range(4, MAX_LEN);
            cc = !ld && ($urandom_range(0, 29) == 0);
            step($urandom_range(0, 99) == 0, ld, MAX_LEN'($urandom), l, 1'($urandom),
                 cc, $urandom_range(0, 3) != 0, 1'($urandom));
        end
        idle();
        idle();

        @(posedge clk);
        @(posedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
